mult_seq_ctrl: RTL and testbench

- Sequencing controller for the shift-add sign-magnitude multiplier datapath that feeds the LED output stage.
- Detects a start request and issues the load strobe, then DW shift/add cycles. It asserts stop, which drives the LED stage's stop/ready input, and holds it until cleared or restarted.
- Pure control: operand and product registers live in the datapath. The controller sees only the multiplier LSB and an optional zero flag from it.

---
 rtl/mult_ctrl_pkg.sv | 7 +
 rtl/mult_bit_counter.sv | 17 +
 rtl/mult_seq_ctrl.sv | 65 ++++++
 tb/tb_mult_seq_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared state encoding and sizing for the multiplier sequencer
package mult_ctrl_pkg;
   localparam int DW_DEF = 8;
   localparam int CW_DEF = $clog2(DW_DEF + 1);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   typedef logic [CW_DEF-1:0] count_t;
endpackage

// File: rtl/mult_bit_counter.sv
// mult_bit_counter: iteration counter with clear priority and terminal flag at DW-1
module mult_bit_counter #(
   parameter int DW = 8,
   parameter int CW = $clog2(DW + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          term
);
   always_ff @(posedge clk)
      if (!rst_n || clr) count <= '0;
      else if (en) count <= count + 1'b1;
   assign term = count == CW'(DW - 1);
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-add multiplier sequencer; EARLY_DONE_EN ends a run once the multiplier is exhausted
module mult_seq_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = $clog2(DW + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic          i_clear,
   input  logic          i_mplr_lsb,
   input  logic          i_mplr_zero,
   output logic          o_load,
   output logic          o_add,
   output logic          o_shift,
   output logic          o_busy,
   output logic          o_stop,
   output logic [CW-1:0] o_count
);
   state_t state_q, state_n;
   logic start_q, rise, run, zero_stop, term, clr;
   // start_q resets high so a start held through reset release is not an edge
   always_ff @(posedge clk)
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b1;
      end else begin
         state_q <= state_n;
         start_q <= i_start;
      end
   assign rise = i_start & ~start_q;
   assign run  = state_q == RUN;
`ifdef EARLY_DONE_EN
   assign zero_stop = run & i_mplr_zero;
`else
   logic unused;
   assign unused    = i_mplr_zero;
   assign zero_stop = 1'b0;
`endif
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    state_n = i_clear ? IDLE : rise ? LOAD : IDLE;
         LOAD:    state_n = i_clear ? IDLE : RUN;
         RUN:     state_n = i_clear ? IDLE : (zero_stop || term) ? DONE : RUN;
         DONE:    state_n = i_clear ? IDLE : rise ? LOAD : DONE;
         default: state_n = IDLE;
      endcase
   end
   assign o_load  = state_q == LOAD;
   assign o_busy  = o_load | run;
   assign o_stop  = state_q == DONE;
   assign o_shift = run & ~zero_stop;
   assign o_add   = o_shift & i_mplr_lsb;
   assign clr     = i_clear | (state_n == LOAD);
   mult_bit_counter #(.DW(DW), .CW(CW)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .en   (o_shift),
      .count(o_count),
      .term (term)
   );
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed bench with a cycle-level reference model and a small shift-add datapath
module tb_mult_seq_ctrl;
   localparam int DW = 8;
   localparam int CW = 4;
`ifdef EARLY_DONE_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b1, i_clear = 1'b0;
   logic i_mplr_lsb, i_mplr_zero;
   logic o_load, o_add, o_shift, o_busy, o_stop;
   logic [CW-1:0] o_count;
   int errors = 0, checks = 0, cyc = 0;
   always #5 clk = ~clk;
   mult_seq_ctrl #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_clear(i_clear),
      .i_mplr_lsb(i_mplr_lsb), .i_mplr_zero(i_mplr_zero),
      .o_load(o_load), .o_add(o_add), .o_shift(o_shift),
      .o_busy(o_busy), .o_stop(o_stop), .o_count(o_count)
   );
   logic [7:0] mcand_in = 8'd0, mplr_in = 8'd0, dp_mplr = 8'd0;
   logic [15:0] dp_mcand = 16'd0, dp_acc = 16'd0;
   always @(posedge clk)
      if (o_load) begin
         dp_mcand <= {8'd0, mcand_in};
         dp_mplr  <= mplr_in;
         dp_acc   <= 16'd0;
      end else if (o_shift) begin
         if (o_add) dp_acc <= dp_acc + dp_mcand;
         dp_mcand <= dp_mcand << 1;
         dp_mplr  <= dp_mplr >> 1;
      end
   assign i_mplr_lsb  = dp_mplr[0];
   assign i_mplr_zero = dp_mplr == 8'd0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask
   // ph: 0 idle, 1 load/run started at cycle base, 2 product held
   int ph = 0, base = 0, iters = 0;
   logic sp = 1'b1;
   always @(posedge clk) begin
      logic rise;
      int off;
      rise = i_start & ~sp;
      sp = i_start;
      if (!rst_n) begin
         ph = 0; iters = 0; sp = 1'b1;
      end else if (i_clear) begin
         ph = 0; iters = 0;
      end else if (ph != 1) begin
         if (rise) begin ph = 1; base = cyc + 1; iters = 0; end
      end else begin
         off = cyc - base;
         if (off >= 1) begin
            if (EARLY && i_mplr_zero) ph = 2;
            else begin
               iters = off;
               if (off == DW) ph = 2;
            end
         end
      end
      cyc++;
   end
   always @(negedge clk) begin
      logic ld, rn, zs;
      int ec;
      ld = ph == 1 && cyc == base;
      rn = ph == 1 && cyc > base;
      zs = EARLY && i_mplr_zero;
      ec = ph == 1 ? (rn ? cyc - base - 1 : 0) : iters;
      chk("load", o_load, ld);
      chk("busy", o_busy, ph == 1);
      chk("stop", o_stop, ph == 2);
      chk("shift", o_shift, rn && !zs);
      chk("add", o_add, rn && !zs && i_mplr_lsb);
      chk("count", o_count, ec);
   end
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic wait_stop(input int pulse_at, output int lat, output int nsh, output logic [7:0] adds);
      lat = 0; nsh = 0; adds = 8'd0;
      while (!o_stop && lat < 30) begin
         if (o_shift) begin adds[nsh[2:0]] = o_add; nsh++; end
         if (lat == pulse_at) i_start = 1'b0;
         if (lat == pulse_at + 1) i_start = 1'b1;
         tick();
         lat++;
      end
   endtask
   task automatic start_run(input logic [7:0] a, input logic [7:0] b);
      mcand_in = a; mplr_in = b;
      i_start = 1'b0;
      tick();
      i_start = 1'b1;
      tick();
   endtask
   initial begin
      int lat, nsh, seen;
      logic [7:0] adds;
      tick(3);
      rst_n = 1'b1;
      tick(20);
      chk("rst_hold_stop", o_stop, 0);
      chk("rst_hold_busy", o_busy, 0);
      start_run(8'd13, 8'd11);
      chk("load_strobe", o_load, 1);
      wait_stop(-5, lat, nsh, adds);
      chk("add_seq", adds, 8'b0000_1011);
      chk("shifts_13x11", nsh, EARLY ? 4 : 8);
      chk("stop_latency", lat, EARLY ? 6 : 9);
      chk("count_done", o_count, EARLY ? 4 : 8);
      chk("product_143", dp_acc, 16'd143);
      start_run(8'd200, 8'hFF);
      chk("restart_stop_low", o_stop, 0);
      chk("restart_load", o_load, 1);
      wait_stop(3, lat, nsh, adds);
      chk("midrun_rise_shifts", nsh, 8);
      chk("midrun_rise_lat", lat, 9);
      chk("product_51000", dp_acc, 16'd51000);
      start_run(8'd13, 8'hFF);
      tick(4);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      chk("abort_busy", o_busy, 0);
      chk("abort_count", o_count, 0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (o_stop) seen++;
         tick();
      end
      chk("abort_no_stop", seen, 0);
      i_start = 1'b0;
      tick();
      i_start = 1'b1;
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      chk("clear_rise_load", o_load, 0);
      tick(3);
      chk("clear_rise_busy", o_busy, 0);
      start_run(8'd5, 8'd3);
      wait_stop(-5, lat, nsh, adds);
      chk("early_shifts", nsh, EARLY ? 2 : 8);
      chk("early_count", o_count, EARLY ? 2 : 8);
      chk("early_lat", lat, EARLY ? 4 : 9);
      chk("product_15", dp_acc, 16'd15);
      start_run(8'd7, 8'hFF);
      tick(3);
      rst_n = 1'b0;
      tick();
      chk("rst_mid_busy", o_busy, 0);
      chk("rst_mid_shift", o_shift, 0);
      chk("rst_mid_count", o_count, 0);
      rst_n = 1'b1;
      tick(3);
      chk("rst_mid_no_start", o_busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
